// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS-style load/store unit with alignment checks, lane steering and an in-order pending FIFO
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_rt,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [31:0]         bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                resp_valid,
  output logic                resp_is_load,
  output logic [31:0]         resp_data,
  output logic                exc_valid,
  output logic                exc_store,
  output logic [31:0]         exc_badvaddr
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int SB_W  = DATA_W / 8;
  localparam int LANES = DATA_W / 32;
  localparam int PW    = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam int CW    = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);
  localparam logic [PW-1:0] LAST    = PW'(OUTSTANDING - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  function automatic logic is_ld(input logic [3:0] op);
    return op <= 4'd6;
  endfunction

  function automatic logic is_st(input logic [3:0] op);
    return op inside {[4'd8:4'd12]};
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic [31:0]   addr_q, rt_q;
  logic [3:0]    f_op  [OUTSTANDING];
  logic [2:0]    f_off [OUTSTANDING];
  logic [31:0]   f_rt  [OUTSTANDING];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          exc_valid_q, exc_store_q;
  logic [31:0]   exc_addr_q;
  logic          accept, mis, start, push, pop;
  logic [1:0]    w, hw;
  logic          ln, hl;
  logic [3:0]    strb4, h_op;
  logic [31:0]   wd, word, h_rt, ld;
  logic [7:0]    bt;
  logic [15:0]   hh;

  assign req_ready = state_q == IDLE && cnt_q < MAX_CNT;
  assign accept    = req_valid && req_ready;
  assign mis       = (req_op inside {4'd2, 4'd3, 4'd9} && req_addr[0]) ||
                     (req_op inside {4'd4, 4'd10} && req_addr[1:0] != 2'b00);
  assign start     = accept && !mis && (is_ld(req_op) || is_st(req_op));
  assign push      = state_q == ISSUE && bus_addr_ok;
  assign pop       = bus_data_ok && cnt_q != '0;

  // State register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;

  // Next state: enter ISSUE on an aligned memory op, leave once the address is taken
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (start ? ISSUE : IDLE) : (bus_addr_ok ? IDLE : ISSUE);
  end

  // Capture the request being issued so bus outputs stay stable while waiting
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      op_q   <= '0;
      addr_q <= '0;
      rt_q   <= '0;
    end else if (start) begin
      op_q   <= req_op;
      addr_q <= req_addr;
      rt_q   <= req_rt;
    end

  // Misaligned requests raise a one-cycle exception pulse instead of a bus access
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      exc_valid_q <= 1'b0;
      exc_store_q <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      exc_valid_q <= accept && mis;
      exc_store_q <= accept && mis && is_st(req_op);
      exc_addr_q  <= accept && mis ? req_addr : '0;
    end

  assign exc_valid    = exc_valid_q;
  assign exc_store    = exc_store_q;
  assign exc_badvaddr = exc_addr_q;

  assign w  = addr_q[1:0];
  assign ln = DATA_W == 64 && addr_q[2];

  // Byte strobes and lane data for the pending store, within one 32-bit word
  always_comb begin
    strb4 = 4'h0;
    wd    = 32'h0;
    case (op_q)
      4'd8:  begin strb4 = 4'b0001 << w; wd = {4{rt_q[7:0]}}; end
      4'd9:  begin strb4 = 4'b0011 << w; wd = {2{rt_q[15:0]}}; end
      4'd10: begin strb4 = 4'hF;         wd = rt_q; end
      4'd11: begin strb4 = 4'hF >> ~w;   wd = rt_q >> {~w, 3'b000}; end
      4'd12: begin strb4 = 4'hF << w;    wd = rt_q << {w, 3'b000}; end
      default: ;
    endcase
  end

  assign bus_req   = state_q == ISSUE;
  assign bus_wr    = bus_req && is_st(op_q);
  assign bus_addr  = bus_req ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_wstrb = bus_req ? SB_W'(strb4) << {ln, 2'b00} : '0;
  assign bus_wdata = bus_req ? {LANES{wd}} : '0;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q == LAST ? '0 : wp_q + PW'(1);
      if (pop) rp_q <= rp_q == LAST ? '0 : rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end

  // Pending-entry storage; stale contents are harmless because count gates every read
  always_ff @(posedge clk)
    if (push) begin
      f_op[wp_q]  <= op_q;
      f_off[wp_q] <= addr_q[2:0];
      f_rt[wp_q]  <= rt_q;
    end

  assign h_op = f_op[rp_q];
  assign h_rt = f_rt[rp_q];
  assign hw   = f_off[rp_q][1:0];
  assign hl   = DATA_W == 64 && f_off[rp_q][2];
  assign word = 32'(bus_rdata >> {hl, 5'b00000});
  assign bt   = 8'(word >> {hw, 3'b000});
  assign hh   = 16'(word >> {hw[1], 4'b0000});

  // Load result extraction and LWL/LWR merge with the old register value
  always_comb begin
    ld = 32'h0;
    case (h_op)
      4'd0: ld = {{24{bt[7]}}, bt};
      4'd1: ld = {24'h0, bt};
      4'd2: ld = {{16{hh[15]}}, hh};
      4'd3: ld = {16'h0, hh};
      4'd4: ld = word;
      4'd5: ld = (word << {~hw, 3'b000}) | (h_rt & ~(32'hFFFFFFFF << {~hw, 3'b000}));
      4'd6: ld = (word >> {hw, 3'b000}) | (h_rt & ~(32'hFFFFFFFF >> {hw, 3'b000}));
      default: ;
    endcase
  end

  assign resp_valid   = pop;
  assign resp_is_load = pop && is_ld(h_op);
  assign resp_data    = pop ? ld : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the load/store unit at 32-bit and 64-bit bus widths
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, bus_req, bus_wr, bus_addr_ok = 0, bus_data_ok = 0;
  logic [3:0]  req_op = 0, bus_wstrb;
  logic [31:0] req_addr = 0, req_rt = 0, bus_addr, bus_wdata, bus_rdata = 0, resp_data, exc_badvaddr;
  logic        resp_valid, resp_is_load, exc_valid, exc_store;

  logic        req_valid_w = 0, req_ready_w, bus_req_w, bus_wr_w, bus_addr_ok_w = 0, bus_data_ok_w = 0;
  logic [3:0]  req_op_w = 0;
  logic [7:0]  bus_wstrb_w;
  logic [31:0] req_addr_w = 0, req_rt_w = 0, bus_addr_w, resp_data_w, exc_badvaddr_w;
  logic [63:0] bus_wdata_w, bus_rdata_w = 0;
  logic        resp_valid_w, resp_is_load_w, exc_valid_w, exc_store_w;

  int errors = 0, checks = 0;

  typedef struct packed {logic ld; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t sbw[$];
  exp_t got;

  mem_access_unit #(.DATA_W(32), .OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_rt(req_rt), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .resp_valid(resp_valid), .resp_is_load(resp_is_load), .resp_data(resp_data),
    .exc_valid(exc_valid), .exc_store(exc_store), .exc_badvaddr(exc_badvaddr)
  );

  mem_access_unit #(.DATA_W(64), .OUTSTANDING(2)) dut_w (
    .clk(clk), .resetn(resetn), .req_valid(req_valid_w), .req_ready(req_ready_w), .req_op(req_op_w),
    .req_addr(req_addr_w), .req_rt(req_rt_w), .bus_req(bus_req_w), .bus_wr(bus_wr_w), .bus_addr(bus_addr_w),
    .bus_wstrb(bus_wstrb_w), .bus_wdata(bus_wdata_w), .bus_addr_ok(bus_addr_ok_w), .bus_data_ok(bus_data_ok_w),
    .bus_rdata(bus_rdata_w), .resp_valid(resp_valid_w), .resp_is_load(resp_is_load_w), .resp_data(resp_data_w),
    .exc_valid(exc_valid_w), .exc_store(exc_store_w), .exc_badvaddr(exc_badvaddr_w)
  );

  // Scoreboard: every 32-bit response is popped against the oldest expected entry
  always @(negedge clk)
    if (resp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: resp_valid=1 data=%h, required no response", resp_data);
      end else begin
        got = sb.pop_front();
        if ({resp_is_load, resp_data} !== {got.ld, got.data}) begin
          errors++;
          $display("FAIL resp: is_load=%0b data=%h, required is_load=%0b data=%h", resp_is_load, resp_data, got.ld, got.data);
        end
      end
    end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt);
    int n = 0;
    req_valid = 1; req_op = op; req_addr = a; req_rt = rt;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready=%b, required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic addr_phase;
    bus_addr_ok = 1; @(posedge clk); #1; bus_addr_ok = 0;
  endtask

  task automatic data_phase(input logic [31:0] rd);
    bus_rdata = rd; bus_data_ok = 1; @(posedge clk); #1; bus_data_ok = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({bus_req, resp_valid, exc_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: req/resp/exc=%b, required 000", {bus_req, resp_valid, exc_valid});
    end
    checks++;
    if ({bus_addr, bus_wstrb, bus_wdata, resp_data, exc_badvaddr} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h strb=%h wdata=%h resp=%h bad=%h, required all 0",
                         bus_addr, bus_wstrb, bus_wdata, resp_data, exc_badvaddr);
    end
    @(posedge clk); #1;
    resetn = 1;
  endtask

  task automatic test_ops;
    typedef struct packed {logic [3:0] op; logic [31:0] a, rt, rd; logic [3:0] strb; logic [31:0] wd, resp;} vec_t;
    vec_t v[18] = '{
      '{4'd9,  32'h1002, 32'h0000ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h0},
      '{4'd5,  32'h3001, 32'h11223344, 32'hAABBCCDD, 4'h0, 32'h0,        32'hCCDD3344},
      '{4'd6,  32'h3001, 32'h11223344, 32'hAABBCCDD, 4'h0, 32'h0,        32'h11AABBCC},
      '{4'd5,  32'h3003, 32'h11223344, 32'hAABBCCDD, 4'h0, 32'h0,        32'hAABBCCDD},
      '{4'd6,  32'h3000, 32'h11223344, 32'hAABBCCDD, 4'h0, 32'h0,        32'hAABBCCDD},
      '{4'd0,  32'h5003, 32'h0,        32'h80123456, 4'h0, 32'h0,        32'hFFFFFF80},
      '{4'd1,  32'h5003, 32'h0,        32'h80123456, 4'h0, 32'h0,        32'h00000080},
      '{4'd0,  32'h5000, 32'h0,        32'h0000017F, 4'h0, 32'h0,        32'h0000007F},
      '{4'd2,  32'h5002, 32'h0,        32'h80011234, 4'h0, 32'h0,        32'hFFFF8001},
      '{4'd3,  32'h5002, 32'h0,        32'h80011234, 4'h0, 32'h0,        32'h00008001},
      '{4'd2,  32'h5000, 32'h0,        32'h80011234, 4'h0, 32'h0,        32'h00001234},
      '{4'd4,  32'h5000, 32'h0,        32'hDEADBEEF, 4'h0, 32'h0,        32'hDEADBEEF},
      '{4'd8,  32'h6001, 32'h1234565A, 32'h0,        4'h2, 32'h5A5A5A5A, 32'h0},
      '{4'd10, 32'h6000, 32'hCAFEF00D, 32'h0,        4'hF, 32'hCAFEF00D, 32'h0},
      '{4'd11, 32'h6001, 32'h11223344, 32'h0,        4'h3, 32'h00001122, 32'h0},
      '{4'd12, 32'h6001, 32'h11223344, 32'h0,        4'hE, 32'h22334400, 32'h0},
      '{4'd11, 32'h6003, 32'h11223344, 32'h0,        4'hF, 32'h11223344, 32'h0},
      '{4'd12, 32'h6000, 32'h11223344, 32'h0,        4'hF, 32'h11223344, 32'h0}
    };
    for (int i = 0; i < 18; i++) begin
      sb.push_back('{!v[i].op[3], v[i].resp});
      send(v[i].op, v[i].a, v[i].rt);
      repeat (2) begin
        checks++;
        if ({bus_req, bus_wr, bus_addr, bus_wstrb} !== {1'b1, v[i].op[3], v[i].a & 32'hFFFFFFFC, v[i].strb}) begin
          errors++; $display("FAIL issue[%0d]: req=%b wr=%b addr=%h strb=%h, required 1 %b %h %h", i,
                             bus_req, bus_wr, bus_addr, bus_wstrb, v[i].op[3], v[i].a & 32'hFFFFFFFC, v[i].strb);
        end
        @(posedge clk); #1;
      end
      if (v[i].op[3]) begin
        checks++;
        if (bus_wdata !== v[i].wd) begin
          errors++; $display("FAIL wdata[%0d]: %h, required %h", i, bus_wdata, v[i].wd);
        end
      end
      addr_phase;
      checks++;
      if (bus_req !== 1'b0) begin
        errors++; $display("FAIL release[%0d]: bus_req=%b, required 0", i, bus_req);
      end
      data_phase(v[i].rd);
    end
  endtask

  task automatic test_misaligned;
    logic [3:0]  ops[6] = '{4'd4, 4'd10, 4'd9, 4'd2, 4'd3, 4'd7};
    logic [31:0] as[6]  = '{32'h2001, 32'h2002, 32'h1001, 32'h2003, 32'h2001, 32'h2001};
    logic        exc;
    for (int i = 0; i < 6; i++) begin
      exc = ops[i] != 4'd7;
      send(ops[i], as[i], 32'h0);
      checks++;
      if ({exc_valid, exc_store, exc_badvaddr, bus_req} !== {exc, ops[i][3] & exc, exc ? as[i] : 32'h0, 1'b0}) begin
        errors++; $display("FAIL exc[%0d]: valid=%b store=%b bad=%h req=%b, required %b %b %h 0", i,
                           exc_valid, exc_store, exc_badvaddr, bus_req, exc, ops[i][3] & exc, exc ? as[i] : 32'h0);
      end
      @(posedge clk); #1;
      checks++;
      if ({exc_valid, bus_req, req_ready} !== 3'b001) begin
        errors++; $display("FAIL exc_after[%0d]: valid/req/ready=%b, required 001", i, {exc_valid, bus_req, req_ready});
      end
    end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    logic rdy;
    bus_addr_ok = 1; req_valid = 1; req_op = 4'd4; req_rt = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      req_addr = 32'h7000 + 32'(idx * 4);
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin sb.push_back('{1'b1, 32'(32'h11111111 * (idx + 1))}); idx++; end
    end
    req_addr = 32'h7008;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({req_ready, bus_req} !== 2'b00) begin
        errors++; $display("FAIL stall: ready/req=%b, required 00", {req_ready, bus_req});
      end
    end
    data_phase(32'h11111111);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL after_pop: req_ready=%b, required 1", req_ready);
    end
    sb.push_back('{1'b1, 32'h33333333});
    @(posedge clk); #1;
    req_valid = 0;
    checks++;
    if ({bus_req, bus_addr} !== {1'b1, 32'h7008}) begin
      errors++; $display("FAIL third_issue: req=%b addr=%h, required 1 00007008", bus_req, bus_addr);
    end
    data_phase(32'h22222222);
    bus_addr_ok = 0;
    checks++;
    if ({bus_req, req_ready} !== 2'b01) begin
      errors++; $display("FAIL push_pop: req/ready=%b, required 01", {bus_req, req_ready});
    end
    data_phase(32'h33333333);
    bus_data_ok = 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL empty_data_ok: resp_valid=%b, required 0", resp_valid);
    end
    @(posedge clk); #1;
    bus_data_ok = 0;
  endtask

  task automatic test_reset_inflight;
    send(4'd10, 32'h8000, 32'h12345678);
    #2 resetn = 0;
    #1;
    checks++;
    if ({bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_issue: req=%b wr=%b addr=%h strb=%h wdata=%h, required all 0",
                         bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata);
    end
    @(posedge clk); #1;
    resetn = 1;
    send(4'd4, 32'h8000, 32'h0); addr_phase;
    send(4'd4, 32'h8004, 32'h0); addr_phase;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL inflight_full: req_ready=%b, required 0", req_ready);
    end
    #2 resetn = 0;
    bus_rdata = 32'hFFFFFFFF; bus_data_ok = 1;
    #1;
    checks++;
    if ({resp_valid, resp_is_load, resp_data, bus_req, req_ready} !== {35'h0, 1'b1}) begin
      errors++; $display("FAIL reset_flight: resp=%b ld=%b data=%h req=%b ready=%b, required 0 0 0 0 1",
                         resp_valid, resp_is_load, resp_data, bus_req, req_ready);
    end
    @(posedge clk); #1;
    resetn = 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL stray_data_ok: resp_valid=%b, required 0", resp_valid);
    end
    @(posedge clk); #1;
    bus_data_ok = 0;
  endtask

  task automatic test_lane64;
    logic [3:0]  ops[5]  = '{4'd0, 4'd4, 4'd10, 4'd9, 4'd11};
    logic [31:0] as[5]   = '{32'h4005, 32'h4004, 32'h4004, 32'h4006, 32'h4001};
    logic [31:0] rts[5]  = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0000BEEF, 32'h11223344};
    logic [63:0] rds[5]  = '{64'h0000_8000_0000_0000, 64'h12345678_89ABCDEF, 64'h0, 64'h0, 64'h0};
    logic [7:0]  strb[5] = '{8'h00, 8'h00, 8'hF0, 8'hC0, 8'h03};
    logic [63:0] wds[5]  = '{64'h0, 64'h0, 64'hCAFEF00D_CAFEF00D, 64'hBEEFBEEF_BEEFBEEF, 64'h00001122_00001122};
    logic [31:0] rsp[5]  = '{32'hFFFFFF80, 32'h12345678, 32'h0, 32'h0, 32'h0};
    int n;
    for (int i = 0; i < 5; i++) begin
      sbw.push_back('{!ops[i][3], rsp[i]});
      req_valid_w = 1; req_op_w = ops[i]; req_addr_w = as[i]; req_rt_w = rts[i];
      n = 0;
      while (req_ready_w !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n == 50) begin
        checks++; errors++; $display("FAIL w_timeout[%0d]: req_ready=%b, required 1", i, req_ready_w);
      end
      @(posedge clk); #1;
      req_valid_w = 0;
      checks++;
      if ({bus_req_w, bus_wr_w, bus_addr_w, bus_wstrb_w} !== {1'b1, ops[i][3], as[i] & 32'hFFFFFFF8, strb[i]}) begin
        errors++; $display("FAIL w_issue[%0d]: req=%b wr=%b addr=%h strb=%h, required 1 %b %h %h", i,
                           bus_req_w, bus_wr_w, bus_addr_w, bus_wstrb_w, ops[i][3], as[i] & 32'hFFFFFFF8, strb[i]);
      end
      if (ops[i][3]) begin
        checks++;
        if (bus_wdata_w !== wds[i]) begin
          errors++; $display("FAIL w_wdata[%0d]: %h, required %h", i, bus_wdata_w, wds[i]);
        end
      end
      bus_addr_ok_w = 1; @(posedge clk); #1; bus_addr_ok_w = 0;
      bus_rdata_w = rds[i]; bus_data_ok_w = 1;
      @(negedge clk);
      got = sbw.pop_front();
      checks++;
      if ({resp_valid_w, resp_is_load_w, resp_data_w} !== {1'b1, got.ld, got.data}) begin
        errors++; $display("FAIL w_resp[%0d]: valid=%b ld=%b data=%h, required 1 %b %h", i,
                           resp_valid_w, resp_is_load_w, resp_data_w, got.ld, got.data);
      end
      @(posedge clk); #1;
      bus_data_ok_w = 0;
    end
  endtask

  initial begin
    #1 resetn = 0;
    test_reset;
    test_ops;
    test_misaligned;
    test_back_to_back;
    test_reset_inflight;
    test_lane64;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 32, bus data width, 32 or 64; OUTSTANDING, 2, max in-flight bus transactions, 1..4; OFF_W = log2(DATA_W/8), derived.
REQ-002 Ports (name, direction, width, meaning), one per line:
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  request handshake; a request is accepted when both are high.
REQ-006 req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; other codes are no-op (accepted, no effect).
REQ-007 req_addr  in  32  virtual byte address.
REQ-008 req_rt  in  32  store data, or old rt value for LWL/LWR merge.
REQ-009 bus_req, bus_wr  out  1,1  bus request, write flag.
REQ-010 bus_addr  out  32  req_addr with low OFF_W bits cleared.
REQ-011 bus_wstrb, bus_wdata  out  DATA_W/8, DATA_W  byte enables, lane-positioned write data.
REQ-012 bus_addr_ok, bus_data_ok, bus_rdata  in  1,1,DATA_W  address accepted, response, read data.
REQ-013 resp_valid, resp_is_load, resp_data  out  1,1,32  one-cycle in-order completion pulse.
REQ-014 exc_valid, exc_store, exc_badvaddr  out  1,1,32  alignment exception pulse: AdES if exc_store, else AdEL; faulting address.

Function
REQ-015 Fields: o = req_addr[OFF_W-1:0]; w = o[1:0]; L = 32-bit lane index = o>>2 (always 0 when DATA_W=32).
REQ-016 Misalignment: LH/LHU/SH with o[0]=1, or LW/SW with w!=0; every other op (including LWL/LWR/SWL/SWR) never faults.
REQ-017 FSM: states IDLE and ISSUE; req_ready = (state==IDLE) && (count < OUTSTANDING).
REQ-018 Accepted aligned memory op: fields registered, next state ISSUE; bus_req high with stable outputs until the cycle bus_addr_ok=1, then IDLE.
REQ-019 Accepted misaligned op: next cycle exc_valid=1 for one cycle with exc_store and exc_badvaddr; no bus request, no FIFO entry; state stays IDLE.
REQ-020 Pending FIFO (depth OUTSTANDING) stores op, o, rt; it is pushed on bus_req && bus_addr_ok and popped on bus_data_ok; count tracks occupancy.
REQ-021 Same-cycle push and pop: count unchanged, both take effect; bus_data_ok with empty FIFO is ignored (no pulse, count stays 0).
REQ-022 Strobes, shifted left by 4*L lanes: SB 1<<w; SH 3<<w; SW 4'hF; SWL 4'hF>>(3-w); SWR (4'hF<<w)&4'hF; loads: 0.
REQ-023 Write data, replicated across all 32-bit lanes: SB byte replicated x4; SH half replicated x2; SW rt; SWL rt>>8*(3-w); SWR rt<<8*w.
REQ-024 Load result, taken from lane L of bus_rdata as word W: LB/LBU byte w sign/zero-extended; LH/LHU half w[1] sign/zero-extended; LW W; LWL (W<<8*(3-w)) | (rt & ~(32'hFFFFFFFF<<8*(3-w))); LWR (W>>8*w) | (rt & ~(32'hFFFFFFFF>>8*w)).
REQ-025 On bus_data_ok with a non-empty FIFO: same cycle, resp_valid=1, resp_is_load = head op is a load, resp_data = load result or 0 for stores; responses are in order.
REQ-026 The block has no response backpressure; the consumer accepts every resp_valid pulse.

Reset
REQ-027 Asynchronous assertion of resetn=0 forces, immediately: state IDLE, count 0, FIFO empty, bus_req=0, resp_valid=0, exc_valid=0, all data outputs 0.
REQ-028 Reset during ISSUE or with transactions in flight drops them silently; bus_data_ok after reset is ignored per REQ-021.
REQ-029 Reset deassertion is synchronised externally; the first request may be accepted in the first cycle after release.

Verification
REQ-030 DATA_W=32, SH addr 0x1002, rt 0x0000ABCD -> bus_wstrb 4'b1100, bus_wdata 0xABCDABCD, bus_addr 0x1000; data_ok -> resp_is_load=0.
REQ-031 LW addr 0x2001 -> exc_valid pulse, exc_store=0, exc_badvaddr 0x2001, bus_req never asserted.
REQ-032 LWL addr 0x3001, rt 0x11223344, rdata 0xAABBCCDD -> resp_data 0xCCDD3344; LWR at the same address -> 0x11AABBCC.
REQ-033 DATA_W=64, LB addr 0x4005, rdata 0x0000_8000_0000_0000 -> lane 1, byte 1 = 0x80 -> resp_data 0xFFFFFF80; bus_addr 0x4000.
REQ-034 OUTSTANDING=2, three back-to-back loads, addr_ok held high, data_ok withheld -> req_ready low after two pushes; one data_ok -> the third issues; responses arrive in order.
REQ-035 Reset asserted with two transactions in flight -> outputs zero immediately; later stray data_ok produces no resp_valid.
